dm_lsu_mem: RTL and testbench

Parametrised data memory with load/store unit for the RISC-V pipeline's MEM stage. It generalises the word-only data memory in three ways:
- configurable depth and data width (32 or 64);
- a valid/ready request handshake with a registered response;
- byte-lane steering with full RV load/store sizing, and optional misaligned accesses split into two word beats.

It sits between the EX/MEM pipeline register and the MEM/WB register. The pipeline stalls while `req_ready` is low.

---
 rtl/dm_pkg.sv | 28 ++
 rtl/dm_bytearray.sv | 26 ++
 rtl/dm_lsu_mem.sv | 158 +++++++++++++++
 tb/tb_dm_lsu_mem.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// Shared definitions for the MEM-stage data memory / load-store unit.
// funct3 encodings, state and access-size enums, and load-result extension.
package dm_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [1:0] {ST_IDLE, ST_ACC0, ST_ACC1, ST_RESP} dm_state_e;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} dm_size_e;

  function automatic logic [63:0] dm_extend(input logic [63:0] data, input dm_size_e size,
                                            input logic is_unsigned);
    logic [63:0] r;
    case (size)
      SZ_B:    r = is_unsigned ? {56'd0, data[7:0]}  : {{56{data[7]}}, data[7:0]};
      SZ_H:    r = is_unsigned ? {48'd0, data[15:0]} : {{48{data[15]}}, data[15:0]};
      SZ_W:    r = is_unsigned ? {32'd0, data[31:0]} : {{32{data[31]}}, data[31:0]};
      default: r = data;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dm_bytearray.sv
// Word-addressed byte-lane RAM: one port, synchronous read, per-lane write enable.
// Contents are not reset.
module dm_bytearray #(
  parameter int WORDS = 128,
  parameter int NB    = 4
) (
  input  logic                     clk,
  input  logic [$clog2(WORDS)-1:0] addr,
  input  logic [NB-1:0]            we,
  input  logic [8*NB-1:0]          wdata,
  output logic [8*NB-1:0]          rdata
);

  for (genvar l = 0; l < NB; l++) begin : g_lane
    logic [7:0] lane_mem [WORDS];
    logic [7:0] rd_q;

    always_ff @(posedge clk) begin
      if (we[l]) lane_mem[addr] <= wdata[8*l +: 8];
      rd_q <= lane_mem[addr];
    end

    assign rdata[8*l +: 8] = rd_q;
  end

endmodule

// File: rtl/dm_lsu_mem.sv
// MEM-stage data memory with load/store unit: byte-lane steering, RV sizing and
// optional two-beat misaligned accesses behind a valid/ready request handshake.
//
// state   | meaning
// IDLE    | ready; array is reading the word at req_addr
// ACC0    | beat 0: store lanes commit / beat-0 read word available
// ACC1    | beat 1 of a split access (word w+1, wrapping)
// RESP    | rsp_valid high for one cycle
module dm_lsu_mem
  import dm_pkg::*;
#(
  parameter int DM_ADDRESS  = 9,
  parameter int DATA_W      = 32,
  parameter bit MISALIGN_EN = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [DM_ADDRESS-1:0] req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [2:0]            req_funct3,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err
);

  localparam int NB    = DATA_W / 8;
  localparam int OW    = $clog2(NB);
  localparam int AW    = DM_ADDRESS - OW;
  localparam int WORDS = (1 << DM_ADDRESS) / NB;

  dm_state_e             state;
  logic                  r_we;
  logic [DM_ADDRESS-1:0] r_addr;
  logic [DATA_W-1:0]     r_wdata;
  logic [2:0]            r_f3;
  logic [DATA_W-1:0]     lo, hi;

  dm_size_e          size;
  logic [3:0]        nbytes;
  logic [2:0]        amask;
  logic [OW-1:0]     off;
  logic [AW-1:0]     widx, widx_nx;
  logic              misal, crosses, err, do_split;
  logic [NB-1:0]     size_mask;
  logic [2*NB-1:0]   wide_be;
  logic [2*DATA_W-1:0] wide_wdata, ld_pair;
  logic [DATA_W-1:0] ld_low, ld_ext;

  logic [AW-1:0]     arr_addr;
  logic [NB-1:0]     arr_we;
  logic [DATA_W-1:0] arr_wdata, arr_rdata;

  assign req_ready = (state == ST_IDLE) && rst_n;

  assign size     = dm_size_e'(r_f3[1:0]);
  assign nbytes   = 4'd1 << r_f3[1:0];
  assign amask    = 3'(nbytes - 4'd1);
  assign off      = r_addr[OW-1:0];
  assign widx     = r_addr[DM_ADDRESS-1:OW];
  assign widx_nx  = widx + 1'b1;
  assign misal    = |(r_addr[2:0] & amask);
  assign crosses  = (4'(off) + nbytes) > 4'(NB);
  assign err      = (r_f3 == 3'b111) || (r_we && r_f3[2]) ||
                    ((DATA_W == 32) && (r_f3 == F3_D || r_f3 == F3_WU)) ||
                    (misal && !MISALIGN_EN);
  assign do_split = crosses && !err;

  // Store data and enables span two words; the upper half feeds beat 1.
  assign size_mask  = NB'((16'd1 << nbytes) - 16'd1);
  assign wide_be    = {{NB{1'b0}}, size_mask} << off;
  assign wide_wdata = {{DATA_W{1'b0}}, r_wdata} << {off, 3'b000};

  // Single-beat loads never reach into hi's bytes, so it is only padding there.
  assign ld_pair = (state == ST_ACC1) ? {arr_rdata, lo} : {hi, arr_rdata};
  assign ld_low  = DATA_W'(ld_pair >> {off, 3'b000});
  assign ld_ext  = DATA_W'(dm_extend(64'(ld_low), size, r_f3[2]));

  always_comb begin
    arr_addr  = req_addr[DM_ADDRESS-1:OW];
    arr_we    = '0;
    arr_wdata = wide_wdata[DATA_W-1:0];
    case (state)
      ST_ACC0: begin
        if (r_we) begin
          arr_addr = widx;
          if (!err) arr_we = wide_be[NB-1:0];
        end else begin
          arr_addr = widx_nx;
        end
      end
      ST_ACC1: begin
        arr_addr  = widx_nx;
        arr_wdata = wide_wdata[2*DATA_W-1:DATA_W];
        if (r_we) arr_we = wide_be[2*NB-1:NB];
      end
      default: ;
    endcase
  end

  dm_bytearray #(.WORDS(WORDS), .NB(NB)) u_array (
    .clk   (clk),
    .addr  (arr_addr),
    .we    (arr_we),
    .wdata (arr_wdata),
    .rdata (arr_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_f3      <= '0;
      lo        <= '0;
      hi        <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            state   <= ST_ACC0;
            r_we    <= req_we;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_f3    <= req_funct3;
          end
        end
        ST_ACC0: begin
          lo <= arr_rdata;
          if (do_split) begin
            state <= ST_ACC1;
          end else begin
            state     <= ST_RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= err;
            rsp_rdata <= (err || r_we) ? '0 : ld_ext;
          end
        end
        ST_ACC1: begin
          hi        <= arr_rdata;
          state     <= ST_RESP;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_rdata <= r_we ? '0 : ld_ext;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_lsu_mem.sv
// Bench for dm_lsu_mem: two instances (misaligned enabled / disabled) checked each
// cycle against a byte-addressed memory model, plus literal expectations.
module tb_dm_lsu_mem;
  import dm_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  vld = '0;
  logic        we = 1'b0;
  logic [8:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [2:0]  f3 = '0;
  logic [1:0]  req_ready, rsp_valid, rsp_err;
  logic [31:0] rdata1, rdata0;

  always #5 clk = ~clk;

  dm_lsu_mem #(.DM_ADDRESS(9), .DATA_W(32), .MISALIGN_EN(1'b1)) u_mis (
    .clk(clk), .rst_n(rst_n), .req_valid(vld[1]), .req_ready(req_ready[1]),
    .req_we(we), .req_addr(addr), .req_wdata(wdata), .req_funct3(f3),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rdata1), .rsp_err(rsp_err[1]));

  dm_lsu_mem #(.DM_ADDRESS(9), .DATA_W(32), .MISALIGN_EN(1'b0)) u_al (
    .clk(clk), .rst_n(rst_n), .req_valid(vld[0]), .req_ready(req_ready[0]),
    .req_we(we), .req_addr(addr), .req_wdata(wdata), .req_funct3(f3),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rdata0), .rsp_err(rsp_err[0]));

  int n_cmp = 0;
  int n_bad = 0;
  bit hold_chk = 1'b0;
  bit [7:0] mem_m [2][512];
  int issued [2] = '{0, 0};
  int done [2] = '{0, 0};
  int cyc [2] = '{0, 0};
  int exp_lat [2];
  logic [31:0] exp_rd [2];
  logic exp_er [2];
  logic [31:0] last_rd [2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  // Byte-addressed reference: size/sign rules applied directly to the byte array.
  task automatic model(input int inst, input logic w, input logic [8:0] a, input logic [31:0] d,
                       input logic [2:0] f, input bit partial,
                       output logic [31:0] rd, output logic er, output int lat);
    int n, ai;
    logic [63:0] v;
    n   = 1 << f[1:0];
    er  = (f == 3'b111) || (w && f[2]) || (f == 3'b011) || (f == 3'b110) ||
          (inst == 0 && (int'(a) % n) != 0);
    lat = (!er && (int'(a) % 4) + n > 4) ? 3 : 2;
    rd  = '0;
    v   = '0;
    if (!er) begin
      for (int i = 0; i < n; i++) begin
        ai = (int'(a) + i) % 512;
        if (w) begin
          if (!partial || (ai / 4 == int'(a) / 4)) mem_m[inst][ai] = d[8*i +: 8];
        end else begin
          v[8*i +: 8] = mem_m[inst][ai];
        end
      end
      if (!w) begin
        if (!f[2] && v[8*n-1]) for (int i = 8*n; i < 64; i++) v[i] = 1'b1;
        rd = v[31:0];
      end
    end
  endtask

  task automatic issue(input int inst, input logic w, input logic [8:0] a, input logic [31:0] d,
                       input logic [2:0] f);
    logic [31:0] r;
    logic e;
    int l;
    @(negedge clk);
    we = w; addr = a; wdata = d; f3 = f;
    vld[inst] = 1'b1;
    model(inst, w, a, d, f, 1'b0, r, e, l);
    exp_rd[inst] = r; exp_er[inst] = e; exp_lat[inst] = l;
    @(posedge clk); #1;
    vld[inst] = 1'b0;
    we = ~w; addr = ~a; wdata = ~d; f3 = ~f;
    issued[inst]++;
    repeat (8) begin
      @(negedge clk); #1;
      if (issued[inst] == done[inst]) break;
    end
  endtask

  always @(negedge clk) begin : cmp
    logic rv, ry, re;
    logic [31:0] rd;
    if (rst_n && !hold_chk) begin
      for (int i = 0; i < 2; i++) begin
        rv = rsp_valid[i]; ry = req_ready[i]; re = rsp_err[i];
        rd = (i == 1) ? rdata1 : rdata0;
        if (issued[i] != done[i]) begin
          cyc[i]++;
          chk($sformatf("valid%0d_c%0d", i, cyc[i]), 32'(rv), 32'(cyc[i] == exp_lat[i]));
          chk($sformatf("busy_ready%0d", i), 32'(ry), 32'd0);
          if (cyc[i] >= exp_lat[i]) begin
            chk($sformatf("rdata%0d", i), rd, exp_rd[i]);
            chk($sformatf("err%0d", i), 32'(re), 32'(exp_er[i]));
            last_rd[i] = rd;
            cyc[i] = 0;
            done[i]++;
          end
        end else begin
          chk($sformatf("idle_valid%0d", i), 32'(rv), 32'd0);
          chk($sformatf("idle_ready%0d", i), 32'(ry), 32'd1);
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [31:0] r;
    logic e;
    int l;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rdata", rdata1, 32'd0);
    chk("rst_err", 32'(rsp_err), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_ready", 32'(req_ready), 32'd3);

    for (int k = 0; k < 128; k++) begin
      issue(1, 1'b1, 9'(4*k), 32'd0, F3_W);
      issue(0, 1'b1, 9'(4*k), 32'd0, F3_W);
    end

    // word store / load and sub-word loads
    issue(1, 1'b1, 9'h010, 32'hDEADBEEF, F3_W);
    issue(1, 1'b0, 9'h010, 32'h0, F3_W);   chk("lit_lw", last_rd[1], 32'hDEADBEEF);
    issue(1, 1'b0, 9'h013, 32'h0, F3_B);   chk("lit_lb", last_rd[1], 32'hFFFFFFDE);
    issue(1, 1'b0, 9'h013, 32'h0, F3_BU);  chk("lit_lbu", last_rd[1], 32'h000000DE);
    issue(1, 1'b0, 9'h012, 32'h0, F3_H);   chk("lit_lh", last_rd[1], 32'hFFFFDEAD);
    issue(1, 1'b0, 9'h012, 32'h0, F3_HU);  chk("lit_lhu", last_rd[1], 32'h0000DEAD);

    // byte merge, misaligned-in-word half
    issue(1, 1'b1, 9'h011, 32'h12345678, F3_B);
    issue(1, 1'b0, 9'h010, 32'h0, F3_W);   chk("lit_merge", last_rd[1], 32'hDEAD78EF);
    issue(1, 1'b0, 9'h011, 32'h0, F3_H);   chk("lit_lh_mis", last_rd[1], 32'hFFFFAD78);
    model(1, 1'b0, 9'h013, 32'h0, F3_B, 1'b0, r, e, l);
    chk("model_lb", r, 32'hFFFFFFDE);

    // split store and loads
    issue(1, 1'b1, 9'h016, 32'hA1B2C3D4, F3_W);
    issue(1, 1'b0, 9'h014, 32'h0, F3_W);   chk("lit_split_lo", last_rd[1], 32'hC3D40000);
    issue(1, 1'b0, 9'h018, 32'h0, F3_W);   chk("lit_split_hi", last_rd[1], 32'h0000A1B2);
    issue(1, 1'b0, 9'h016, 32'h0, F3_W);   chk("lit_split_ld", last_rd[1], 32'hA1B2C3D4);
    issue(1, 1'b0, 9'h017, 32'h0, F3_HU);  chk("lit_split_lhu", last_rd[1], 32'h0000B2C3);

    // wrap at top of memory
    issue(1, 1'b1, 9'h1FF, 32'h0000005A, F3_B);
    issue(1, 1'b1, 9'h000, 32'h00000081, F3_B);
    issue(1, 1'b0, 9'h1FF, 32'h0, F3_H);   chk("lit_wrap_lh", last_rd[1], 32'hFFFF815A);
    model(1, 1'b0, 9'h1FF, 32'h0, F3_H, 1'b0, r, e, l);
    chk("model_wrap_lat", 32'(l), 32'd3);
    issue(1, 1'b1, 9'h1FE, 32'hCAFE1234, F3_W);
    issue(1, 1'b0, 9'h000, 32'h0, F3_W);   chk("lit_wrap_w0", last_rd[1], 32'h0000CAFE);

    // errors
    issue(0, 1'b1, 9'h000, 32'hCAFEF00D, F3_W);
    issue(0, 1'b1, 9'h002, 32'h11111111, F3_W);
    chk("lit_mis_err", 32'(exp_er[0]), 32'd1);
    issue(0, 1'b0, 9'h000, 32'h0, F3_W);   chk("lit_w0_kept", last_rd[0], 32'hCAFEF00D);
    issue(0, 1'b0, 9'h003, 32'h0, F3_H);
    issue(0, 1'b0, 9'h002, 32'h0, F3_H);   chk("lit_al_lh", last_rd[0], 32'hFFFFCAFE);
    issue(1, 1'b1, 9'h010, 32'h55555555, 3'b111);
    issue(1, 1'b0, 9'h010, 32'h0, 3'b111);
    issue(1, 1'b0, 9'h010, 32'h0, F3_D);
    issue(1, 1'b0, 9'h010, 32'h0, F3_WU);
    issue(1, 1'b1, 9'h010, 32'h55555555, F3_BU);
    issue(1, 1'b0, 9'h010, 32'h0, F3_W);   chk("lit_err_nowr", last_rd[1], 32'hDEAD78EF);

    // reset in the middle of a split store
    hold_chk = 1'b1;
    @(negedge clk);
    we = 1'b1; addr = 9'h026; wdata = 32'h11223344; f3 = F3_W; vld[1] = 1'b1;
    model(1, 1'b1, 9'h026, 32'h11223344, F3_W, 1'b1, r, e, l);
    @(posedge clk); #1;
    vld[1] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort_valid", 32'(rsp_valid[1]), 32'd0);
    chk("abort_ready", 32'(req_ready[1]), 32'd0);
    chk("abort_rdata", rdata1, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("abort_rel_ready", 32'(req_ready[1]), 32'd1);
    hold_chk = 1'b0;
    issue(1, 1'b0, 9'h024, 32'h0, F3_W);   chk("lit_abort_w", last_rd[1], 32'h33440000);
    issue(1, 1'b0, 9'h028, 32'h0, F3_W);   chk("lit_abort_w1", last_rd[1], 32'h00000000);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
